// File: rtl/scrambler_pkg.sv
// Purpose    : constants and state encoding shared by the scrambler and descrambler.
// Latency    : n/a (declarations only).
// Backpressure: n/a.
// Contents   : SCR_WIDTH, SCR_POLY, SCR_DEFAULT_SEED, SCR_CNT_W, scr_state_e.
package scrambler_pkg;

    localparam int                  SCR_WIDTH        = 32;
    localparam logic [SCR_WIDTH-1:0] SCR_POLY        = 32'h04C1_1DB7;
    localparam logic [SCR_WIDTH-1:0] SCR_DEFAULT_SEED = 32'hFFFF_FFFF;
    localparam int                  SCR_CNT_W        = 16;

    // IDLE until the first seed is loaded; RUN forever after (reseeds stay in RUN).
    typedef enum logic {
        SCR_IDLE = 1'b0,
        SCR_RUN  = 1'b1
    } scr_state_e;

endpackage

// File: rtl/lfsr_descrambler_if.sv
// Purpose    : seed/input/output handshake bundle for the LFSR (de)scrambler.
// Latency    : n/a (wiring only).
// Backpressure: valid/ready on both the input and output streams.
// Ports      : master drives seed_load/seed/in_valid/in_data/out_ready;
//              slave drives in_ready/out_valid/out_data/word_count/locked.
interface lfsr_descrambler_if
    import scrambler_pkg::*;
#(
    parameter int WIDTH = SCR_WIDTH,
    parameter int CNT_W = SCR_CNT_W
);

    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] word_count;
    logic             locked;

    modport master (
        output seed_load, seed, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, word_count, locked
    );

    modport slave (
        input  seed_load, seed, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, word_count, locked
    );

endinterface

// File: rtl/lfsr_advance.sv
// Purpose    : advances a Galois LFSR by WIDTH steps in one combinational pass.
// Latency    : combinational, 0 cycles.
// Backpressure: none; the caller decides when to register the result.
// Ports      : i_state (current LFSR), o_state (state after WIDTH steps).
module lfsr_advance #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C1_1DB7
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] w_s;

    // One step: shift left, fold the polynomial in when the bit shifted out was 1.
    // Unrolled WIDTH times so every accepted word consumes a fresh WIDTH-bit keystream.
    always_comb begin
        w_s = i_state;
        for (int k = 0; k < WIDTH; k++) begin
            w_s = {w_s[WIDTH-2:0], 1'b0} ^ (w_s[WIDTH-1] ? POLY : '0);
        end
        o_state = w_s;
    end

endmodule

// File: rtl/lfsr_descrambler.sv
// Purpose    : XORs an LFSR keystream onto a 32-bit word stream (descramble; scramble when fed plaintext).
// Latency    : 1 cycle from accept to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready drops while a held output word is not taken; LFSR frozen meanwhile.
// Ports      : clk, reset_n (sync, active-low), bus (lfsr_descrambler_if.slave):
//              seed_load/seed, in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//              word_count (words accepted since seed load), locked (keystream seeded).
module lfsr_descrambler
    import scrambler_pkg::*;
#(
    parameter int               WIDTH        = SCR_WIDTH,
    parameter logic [WIDTH-1:0] POLY         = SCR_POLY,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = SCR_DEFAULT_SEED,
    parameter int               CNT_W        = SCR_CNT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    lfsr_descrambler_if.slave   bus
);

    scr_state_e       r_state;
    scr_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_adv;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_word_count;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_drain;
    logic             w_locked;

    lfsr_advance #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_lfsr_advance (
        .i_state (r_lfsr),
        .o_state (w_lfsr_adv)
    );

    // reset_n gates in_ready so nothing is accepted in the reset cycle even
    // though r_state only clears on the edge. A seed_load cycle never accepts,
    // so the first word after a load always sees the new seed.
    assign w_in_ready = reset_n && (r_state == SCR_RUN) && !bus.seed_load &&
                        (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_drain    = r_out_valid && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= SCR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state / outputs
    always_comb begin
        w_state_nxt = r_state;
        w_locked    = 1'b0;
        case (r_state)
            SCR_IDLE: begin
                if (bus.seed_load) begin
                    w_state_nxt = SCR_RUN;
                end
            end
            SCR_RUN: begin
                w_locked = 1'b1;
            end
            default: begin
                w_state_nxt = SCR_IDLE;
            end
        endcase
    end

    // Datapath: seed load has priority over accept/drain and flushes the held word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lfsr       <= DEFAULT_SEED;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_word_count <= '0;
        end else if (bus.seed_load) begin
            // An all-zero Galois LFSR never leaves zero, so substitute a live seed.
            r_lfsr       <= (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
            r_out_valid  <= 1'b0;
            r_word_count <= '0;
        end else if (w_accept) begin
            r_out_data   <= bus.in_data ^ r_lfsr;
            r_out_valid  <= 1'b1;
            r_lfsr       <= w_lfsr_adv;
            r_word_count <= r_word_count + CNT_W'(1);
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.word_count = r_word_count;
    assign bus.locked     = w_locked;

endmodule

// File: tb/tb_lfsr_descrambler.sv
// Purpose    : directed bench for lfsr_descrambler plus a scramble->descramble round trip.
// Latency    : checks outputs 1 ns after each rising edge.
// Backpressure: drives out_ready low to hold a word; round trip runs at full rate.
module tb_lfsr_descrambler;
    import scrambler_pkg::*;

    logic clk;
    logic reset_n;
    logic rt_mode;
    logic tb_out_ready;

    int n_cmp;
    int n_bad;

    lfsr_descrambler_if ifa ();
    lfsr_descrambler_if ifb ();

    // Instance A is the unit under directed test and the scrambler in the round trip.
    lfsr_descrambler u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    // Instance B descrambles A's output with the same seed.
    lfsr_descrambler u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    assign ifa.out_ready = rt_mode ? ifb.in_ready : tb_out_ready;
    assign ifb.seed_load = ifa.seed_load;
    assign ifb.seed      = ifa.seed;
    assign ifb.in_valid  = ifa.out_valid;
    assign ifb.in_data   = ifa.out_data;
    assign ifb.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] w;
        logic [31:0] rt_seed;
        int          stalls;
        int          matched;

        n_cmp        = 0;
        n_bad        = 0;
        rt_mode      = 1'b0;
        tb_out_ready = 1'b1;
        reset_n      = 1'b0;
        ifa.seed_load = 1'b0;
        ifa.seed      = '0;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;

        // ---------------- reset ----------------
        step();
        ifa.in_valid = 1'b1;
        #1;
        chk("rst_in_ready", ifa.in_ready, 1'b0);
        step();
        chk("rst_out_valid", ifa.out_valid, 1'b0);
        chk("rst_out_data", ifa.out_data, 32'h0);
        chk("rst_word_count", ifa.word_count, 32'h0);
        chk("rst_locked", ifa.locked, 1'b0);
        reset_n = 1'b1;

        // ---------------- idle ignores input ----------------
        for (int i = 0; i < 10; i++) begin
            ifa.in_data = $urandom;
            #1;
            chk("idle_in_ready", ifa.in_ready, 1'b0);
            step();
            chk("idle_out_valid", ifa.out_valid, 1'b0);
            chk("idle_locked", ifa.locked, 1'b0);
            chk("idle_word_count", ifa.word_count, 32'h0);
        end
        ifa.in_valid = 1'b0;

        // ---------------- seed 1, two words ----------------
        ifa.seed_load = 1'b1;
        ifa.seed      = 32'h1;
        #1;
        chk("seed_cycle_in_ready", ifa.in_ready, 1'b0);
        step();
        ifa.seed_load = 1'b0;
        chk("seed1_locked", ifa.locked, 1'b1);
        chk("seed1_count0", ifa.word_count, 32'h0);
        ifa.in_valid = 1'b1;
        ifa.in_data  = 32'hA5A5_A5A4;
        #1;
        chk("seed1_in_ready", ifa.in_ready, 1'b1);
        step();
        chk("w0_valid", ifa.out_valid, 1'b1);
        chk("w0_data", ifa.out_data, 32'hA5A5_A5A5);
        ifa.in_data = 32'h04C1_1DB7;
        step();
        chk("w1_data", ifa.out_data, 32'h0000_0000);
        chk("w1_count", ifa.word_count, 32'd2);
        ifa.in_valid = 1'b0;
        step();
        chk("drain_valid", ifa.out_valid, 1'b0);
        chk("drain_data_hold", ifa.out_data, 32'h0000_0000);
        chk("drain_count", ifa.word_count, 32'd2);

        // ---------------- zero seed -> default seed ----------------
        ifa.seed_load = 1'b1;
        ifa.seed      = 32'h0;
        step();
        ifa.seed_load = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 32'h0;
        step();
        chk("zseed_data", ifa.out_data, 32'hFFFF_FFFF);
        chk("zseed_locked", ifa.locked, 1'b1);
        chk("zseed_count", ifa.word_count, 32'd1);
        ifa.in_valid = 1'b0;
        step();

        // ---------------- backpressure ----------------
        ifa.seed_load = 1'b1;
        ifa.seed      = 32'h1;
        step();
        ifa.seed_load = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 32'h1234_5678;
        step();
        chk("bp_first_data", ifa.out_data, 32'h1234_5679);
        tb_out_ready = 1'b0;
        ifa.in_data  = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", ifa.in_ready, 1'b0);
            step();
            chk("bp_hold_valid", ifa.out_valid, 1'b1);
            chk("bp_hold_data", ifa.out_data, 32'h1234_5679);
            chk("bp_hold_count", ifa.word_count, 32'd1);
        end
        tb_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", ifa.in_ready, 1'b1);
        step();
        chk("bp_second_data", ifa.out_data, 32'h04C1_1DB7);
        chk("bp_second_count", ifa.word_count, 32'd2);
        ifa.in_valid = 1'b0;
        step();
        chk("bp_drained", ifa.out_valid, 1'b0);

        // ---------------- reseed mid-stream ----------------
        ifa.seed_load = 1'b1;
        ifa.seed      = 32'hDEAD_BEEF;
        step();
        ifa.seed_load = 1'b0;
        ifa.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.in_data = $urandom;
            step();
        end
        chk("mid_valid", ifa.out_valid, 1'b1);
        chk("mid_count", ifa.word_count, 32'd3);
        // in_valid stays high through the seed cycle; it must not be accepted.
        ifa.in_data   = 32'hFFFF_FFFF;
        ifa.seed_load = 1'b1;
        ifa.seed      = 32'h1;
        #1;
        chk("reseed_in_ready", ifa.in_ready, 1'b0);
        step();
        ifa.seed_load = 1'b0;
        chk("reseed_flush", ifa.out_valid, 1'b0);
        chk("reseed_count", ifa.word_count, 32'd0);
        chk("reseed_locked", ifa.locked, 1'b1);
        step();
        chk("reseed_data", ifa.out_data, 32'hFFFF_FFFE);
        chk("reseed_count1", ifa.word_count, 32'd1);
        ifa.in_valid = 1'b0;
        step();

        // ---------------- round trip, full rate, reset at word 500 ----------------
        rt_mode       = 1'b1;
        stalls        = 0;
        matched       = 0;
        rt_seed       = $urandom;
        ifa.seed_load = 1'b1;
        ifa.seed      = rt_seed;
        step();
        ifa.seed_load = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                ifa.in_valid = 1'b0;
                reset_n      = 1'b0;
                #1;
                chk("rt_rst_in_ready", ifa.in_ready, 1'b0);
                step();
                chk("rt_rst_a_valid", ifa.out_valid, 1'b0);
                chk("rt_rst_b_valid", ifb.out_valid, 1'b0);
                chk("rt_rst_a_locked", ifa.locked, 1'b0);
                chk("rt_rst_b_locked", ifb.locked, 1'b0);
                reset_n = 1'b1;
                q.delete();
                ifa.seed_load = 1'b1;
                step();
                ifa.seed_load = 1'b0;
            end
            w            = $urandom;
            ifa.in_valid = 1'b1;
            ifa.in_data  = w;
            q.push_back(w);
            #1;
            if (!ifa.in_ready) stalls++;
            step();
            if (ifb.out_valid) begin
                if (q.size() == 0) begin
                    chk("rt_extra_word", 32'h1, 32'h0);
                end else begin
                    chk("rt_word", ifb.out_data, q.pop_front());
                    matched++;
                end
            end
        end
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ifb.out_valid && q.size() != 0) begin
                chk("rt_tail_word", ifb.out_data, q.pop_front());
                matched++;
            end
        end
        // Word 499 was in flight in A when reset hit and is discarded.
        chk("rt_matched", 32'(matched), 32'd999);
        chk("rt_queue_empty", 32'(q.size()), 32'd0);
        chk("rt_stalls", 32'(stalls), 32'd0);
        chk("rt_b_count", ifb.word_count, 32'd500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
